// File: rtl/wdt_heartbeat_supervisor_pkg.sv
// Shared definitions for the heartbeat supervisor: FSM encoding, status counter width
// and the saturating increment used by the miss counter.
package wdt_heartbeat_supervisor_pkg;

    localparam int MISS_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_KICK    = 2'd1,
        ST_STARVED = 2'd2
    } wdt_state_e;

    function automatic logic [MISS_CNT_W-1:0] sat_inc(input logic [MISS_CNT_W-1:0] v);
        if (v == {MISS_CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + MISS_CNT_W'(1);
        end
    endfunction

endpackage

// File: rtl/wdt_hb_edge.sv
// Rising-edge detector for one heartbeat line. The history flop resets to 1 so a line
// already high when reset releases is not mistaken for a beat.
module wdt_hb_edge (
    input  logic clk_sys,
    input  logic rst_sys,
    input  logic hb_in,
    output logic beat
);

    logic hb_prev_q;
    logic hb_prev_d;

    // Track the previous sample every cycle, regardless of supervisor state.
    always_comb begin
        hb_prev_d = hb_in;
    end

    // History register.
    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            hb_prev_q <= 1'b1;
        end else begin
            hb_prev_q <= hb_prev_d;
        end
    end

    assign beat = hb_in & ~hb_prev_q;

endmodule

// File: rtl/wdt_heartbeat_supervisor.sv
// Heartbeat supervisor: kicks the watchdog once per window only if every enabled source
// has beaten; on a miss it stops kicking and latches which sources were silent.
module wdt_heartbeat_supervisor
    import wdt_heartbeat_supervisor_pkg::*;
#(
    parameter int NUM_SRC       = 4,
    parameter int WINDOW_CYCLES = 50000000
) (
    input  logic                  clk_sys,
    input  logic                  rst_sys,
    input  logic [NUM_SRC-1:0]    hb_in,
    input  logic [NUM_SRC-1:0]    src_enable,
    input  logic                  sup_enable,
    input  logic                  force_starve,
    input  logic                  clear_status,
    output logic                  wdt_kick,
    output logic                  starved,
    output logic [NUM_SRC-1:0]    missed_mask,
    output logic [MISS_CNT_W-1:0] miss_count,
    output logic [NUM_SRC-1:0]    hb_seen
);

    localparam int              CNT_W    = $clog2(WINDOW_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW_CYCLES - 1);

    wdt_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_SRC-1:0]    seen_q, seen_d;
    logic [NUM_SRC-1:0]    mask_q, mask_d;
    logic [MISS_CNT_W-1:0] count_q, count_d;
    logic                  kick_q, kick_d;
    logic                  starved_q, starved_d;
    logic [NUM_SRC-1:0]    beat_s;
    logic                  ok_s;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_edge
        wdt_hb_edge u_edge (
            .clk_sys (clk_sys),
            .rst_sys (rst_sys),
            .hb_in   (hb_in[i]),
            .beat    (beat_s[i])
        );
    end

    // Window verdict includes a beat landing on the very last window cycle.
    assign ok_s = (((seen_q | beat_s) & src_enable) == src_enable);

    // Next-state, window counter and status update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        seen_d  = seen_q;
        mask_d  = mask_q;
        count_d = count_q;

        if (clear_status) begin
            mask_d  = {NUM_SRC{1'b0}};
            count_d = {MISS_CNT_W{1'b0}};
        end else begin
            mask_d  = mask_q;
            count_d = count_q;
        end

        case (state_q)
            ST_COLLECT: begin
                seen_d = seen_q | beat_s;
                if (cnt_q == CNT_LAST) begin
                    cnt_d = {CNT_W{1'b0}};
                    if (!sup_enable) begin
                        state_d = ST_KICK;
                    end else if (force_starve || !ok_s) begin
                        // A miss overrides a simultaneous clear.
                        state_d = ST_STARVED;
                        mask_d  = src_enable & ~(seen_q | beat_s);
                        count_d = sat_inc(count_q);
                    end else begin
                        state_d = ST_KICK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_KICK: begin
                state_d = ST_COLLECT;
                cnt_d   = {CNT_W{1'b0}};
                seen_d  = beat_s;
            end
            ST_STARVED: begin
                if (!sup_enable) begin
                    state_d = ST_COLLECT;
                    cnt_d   = {CNT_W{1'b0}};
                    seen_d  = {NUM_SRC{1'b0}};
                end else begin
                    state_d = ST_STARVED;
                end
            end
            default: begin
                state_d = ST_COLLECT;
                cnt_d   = {CNT_W{1'b0}};
                seen_d  = {NUM_SRC{1'b0}};
            end
        endcase

        kick_d    = (state_d == ST_KICK);
        starved_d = (state_d == ST_STARVED);
    end

    // State and output registers.
    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            state_q   <= ST_COLLECT;
            cnt_q     <= {CNT_W{1'b0}};
            seen_q    <= {NUM_SRC{1'b0}};
            mask_q    <= {NUM_SRC{1'b0}};
            count_q   <= {MISS_CNT_W{1'b0}};
            kick_q    <= 1'b0;
            starved_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            seen_q    <= seen_d;
            mask_q    <= mask_d;
            count_q   <= count_d;
            kick_q    <= kick_d;
            starved_q <= starved_d;
        end
    end

    assign wdt_kick    = kick_q;
    assign starved     = starved_q;
    assign missed_mask = mask_q;
    assign miss_count  = count_q;
    assign hb_seen     = seen_q;

endmodule

// File: tb/tb_wdt_heartbeat_supervisor.sv
// Directed bench for wdt_heartbeat_supervisor with NUM_SRC=4, WINDOW_CYCLES=16.
module tb_wdt_heartbeat_supervisor;

    logic       clk_sys = 1'b0;
    logic       rst_sys;
    logic [3:0] hb_in;
    logic [3:0] src_enable;
    logic       sup_enable;
    logic       force_starve;
    logic       clear_status;
    logic       wdt_kick;
    logic       starved;
    logic [3:0] missed_mask;
    logic [7:0] miss_count;
    logic [3:0] hb_seen;

    int total = 0;
    int bad   = 0;

    wdt_heartbeat_supervisor #(.NUM_SRC(4), .WINDOW_CYCLES(16)) dut (
        .clk_sys      (clk_sys),
        .rst_sys      (rst_sys),
        .hb_in        (hb_in),
        .src_enable   (src_enable),
        .sup_enable   (sup_enable),
        .force_starve (force_starve),
        .clear_status (clear_status),
        .wdt_kick     (wdt_kick),
        .starved      (starved),
        .missed_mask  (missed_mask),
        .miss_count   (miss_count),
        .hb_seen      (hb_seen)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [3:0] init_hb;
        logic [3:0] src_en;
        logic [3:0] pulse;
        logic       sup;
        logic       frc;
        logic       exp_kick;
        logic       exp_starved;
        logic [3:0] exp_missed;
        logic [7:0] exp_count;
        logic [3:0] exp_seen;
    } vec_t;

    vec_t vecs [10];

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input logic [3:0] init);
        rst_sys      = 1'b1;
        hb_in        = init;
        clear_status = 1'b0;
        tick();
        tick();
        rst_sys = 1'b0;
    endtask

    initial begin
        // init_hb, src_en, pulse, sup, frc, kick, starved, missed, count, seen
        vecs[0] = '{4'h0, 4'hF, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 8'd0, 4'hF};
        vecs[1] = '{4'h0, 4'hF, 4'hB, 1'b1, 1'b0, 1'b0, 1'b1, 4'h4, 8'd1, 4'hB};
        vecs[2] = '{4'h1, 4'hF, 4'hE, 1'b1, 1'b0, 1'b0, 1'b1, 4'h1, 8'd1, 4'hE};
        vecs[3] = '{4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 8'd0, 4'h0};
        vecs[4] = '{4'h0, 4'h5, 4'h5, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 8'd0, 4'h5};
        vecs[5] = '{4'h0, 4'h5, 4'h4, 1'b1, 1'b0, 1'b0, 1'b1, 4'h1, 8'd1, 4'h4};
        vecs[6] = '{4'h0, 4'hF, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 8'd0, 4'h0};
        vecs[7] = '{4'h0, 4'hF, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 8'd1, 4'hF};
        vecs[8] = '{4'h0, 4'hF, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 8'd0, 4'h0};
        vecs[9] = '{4'h0, 4'h3, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 8'd0, 4'hF};

        // One fresh window per table entry, judged on the cycle after the window end.
        for (int v = 0; v < 10; v++) begin
            src_enable   = vecs[v].src_en;
            sup_enable   = vecs[v].sup;
            force_starve = vecs[v].frc;
            do_reset(vecs[v].init_hb);
            for (int t = 1; t <= 16; t++) begin
                tick();
                if (t == 2) hb_in = vecs[v].init_hb | vecs[v].pulse;
                else if (t == 3) hb_in = vecs[v].init_hb;
            end
            chk($sformatf("vec%0d_kick", v), 32'(wdt_kick), 32'(vecs[v].exp_kick));
            chk($sformatf("vec%0d_starved", v), 32'(starved), 32'(vecs[v].exp_starved));
            chk($sformatf("vec%0d_missed", v), 32'(missed_mask), 32'(vecs[v].exp_missed));
            chk($sformatf("vec%0d_count", v), 32'(miss_count), 32'(vecs[v].exp_count));
            chk($sformatf("vec%0d_seen", v), 32'(hb_seen), 32'(vecs[v].exp_seen));
        end

        // Reset state, then periodic kicks every 17 cycles with all sources beating.
        src_enable = 4'hF; sup_enable = 1'b1; force_starve = 1'b0;
        do_reset(4'h0);
        chk("rst_kick", 32'(wdt_kick), 32'd0);
        chk("rst_starved", 32'(starved), 32'd0);
        chk("rst_missed", 32'(missed_mask), 32'd0);
        chk("rst_count", 32'(miss_count), 32'd0);
        chk("rst_seen", 32'(hb_seen), 32'd0);
        for (int t = 1; t <= 51; t++) begin
            tick();
            chk($sformatf("period_kick_t%0d", t), 32'(wdt_kick), 32'((t % 17) == 16));
            if ((t % 17) == 4) hb_in = 4'hF;
            else if ((t % 17) == 5) hb_in = 4'h0;
        end
        chk("period_starved", 32'(starved), 32'd0);
        chk("period_count", 32'(miss_count), 32'd0);

        // Beat on the last window cycle counts; beat during KICK carries into next window.
        do_reset(4'h0);
        for (int t = 1; t <= 34; t++) begin
            tick();
            if (t == 16) begin
                chk("edge_last_kick", 32'(wdt_kick), 32'd1);
                chk("edge_last_seen", 32'(hb_seen), 32'hF);
            end
            if (t == 33) chk("edge_w2_kick", 32'(wdt_kick), 32'd1);
            if (t == 34) begin
                chk("edge_kickbeat_seen", 32'(hb_seen), 32'h8);
                chk("edge_kickbeat_nokick", 32'(wdt_kick), 32'd0);
                chk("edge_kickbeat_starved", 32'(starved), 32'd0);
            end
            case (t)
                2:       hb_in = 4'h7;
                3:       hb_in = 4'h0;
                15:      hb_in = 4'h8;
                16:      hb_in = 4'h0;
                19:      hb_in = 4'hF;
                20:      hb_in = 4'h0;
                33:      hb_in = 4'h8;
                default: hb_in = hb_in;
            endcase
        end

        // Miss, silence while starved, bypass recovery, forced miss, clear vs miss.
        hb_in = 4'h0;
        do_reset(4'h0);
        for (int t = 1; t <= 16; t++) begin
            tick();
            if (t == 2) hb_in = 4'hB;
            else if (t == 3) hb_in = 4'h0;
        end
        chk("miss_kick", 32'(wdt_kick), 32'd0);
        chk("miss_starved", 32'(starved), 32'd1);
        chk("miss_mask", 32'(missed_mask), 32'h4);
        chk("miss_count", 32'(miss_count), 32'd1);
        begin
            int kicks = 0;
            for (int t = 0; t < 100; t++) begin
                tick();
                if (wdt_kick) kicks++;
            end
            chk("starved_kicks", 32'(kicks), 32'd0);
        end
        chk("starved_hold", 32'(starved), 32'd1);
        chk("starved_seen_frozen", 32'(hb_seen), 32'hB);
        sup_enable = 1'b0;
        tick();
        chk("exit_starved", 32'(starved), 32'd0);
        chk("exit_seen", 32'(hb_seen), 32'h0);
        chk("exit_mask_sticky", 32'(missed_mask), 32'h4);
        chk("exit_count_sticky", 32'(miss_count), 32'd1);
        for (int k = 1; k <= 34; k++) begin
            tick();
            chk($sformatf("bypass_kick_k%0d", k), 32'(wdt_kick), 32'((k % 17) == 16));
        end
        sup_enable = 1'b1; force_starve = 1'b1;
        for (int k = 35; k <= 50; k++) tick();
        chk("force_starved", 32'(starved), 32'd1);
        chk("force_kick", 32'(wdt_kick), 32'd0);
        chk("force_mask", 32'(missed_mask), 32'hF);
        chk("force_count", 32'(miss_count), 32'd2);
        sup_enable = 1'b0;
        tick();
        sup_enable = 1'b1; src_enable = 4'h3;
        for (int k = 1; k <= 15; k++) tick();
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        chk("clrmiss_starved", 32'(starved), 32'd1);
        chk("clrmiss_mask", 32'(missed_mask), 32'h3);
        chk("clrmiss_count", 32'(miss_count), 32'd3);
        sup_enable = 1'b0;
        tick();
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        chk("clear_mask", 32'(missed_mask), 32'h0);
        chk("clear_count", 32'(miss_count), 32'd0);
        force_starve = 1'b0;

        // Reset mid-window drops the partial window and restarts the count.
        src_enable = 4'hF; sup_enable = 1'b1; hb_in = 4'h0;
        do_reset(4'h0);
        for (int t = 1; t <= 15; t++) begin
            tick();
            if (t == 2) hb_in = 4'hF;
            else if (t == 3) hb_in = 4'h0;
        end
        rst_sys = 1'b1;
        tick();
        chk("midrst_kick", 32'(wdt_kick), 32'd0);
        chk("midrst_seen", 32'(hb_seen), 32'h0);
        chk("midrst_starved", 32'(starved), 32'd0);
        rst_sys = 1'b0; src_enable = 4'h0;
        for (int t = 1; t <= 16; t++) begin
            tick();
            if (t == 15) chk("midrst_t15_nokick", 32'(wdt_kick), 32'd0);
        end
        chk("midrst_t16_kick", 32'(wdt_kick), 32'd1);

        // Saturation of the miss counter over 260 forced misses.
        src_enable = 4'hF; sup_enable = 1'b1; force_starve = 1'b1; hb_in = 4'h0;
        do_reset(4'h0);
        for (int i = 1; i <= 260; i++) begin
            for (int t = 1; t <= 16; t++) tick();
            if (i == 1 || i == 254 || i == 255 || i == 256 || i == 260) begin
                chk($sformatf("sat_count_i%0d", i), 32'(miss_count), (i < 255) ? 32'(i) : 32'd255);
                chk($sformatf("sat_starved_i%0d", i), 32'(starved), 32'd1);
            end
            sup_enable = 1'b0;
            tick();
            sup_enable = 1'b1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
